nios_switch_ctrl: RTL and testbench

NIOS_SWITCH_CTRL -- requirements
Module: nios_switch_ctrl

---
 rtl/nios_switch_ctrl_pkg.sv | 18 +
 rtl/nios_switch_ctrl_if.sv | 24 ++
 rtl/nios_switch_debounce.sv | 78 +++++++
 rtl/nios_switch_ctrl.sv | 92 +++++++++
 tb/tb_nios_switch_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/nios_switch_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nios_switch_ctrl_pkg : register map and debounce state type -- rev 1.0
// ---------------------------------------------------------------------------
package nios_switch_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RAW  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [0:0] {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } db_state_e;

endpackage
`default_nettype wire

// File: rtl/nios_switch_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nios_switch_ctrl_if : Avalon-MM slave bus bundle -- rev 1.0
// ---------------------------------------------------------------------------
interface nios_switch_ctrl_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write, writedata,
    output readdata
  );

endinterface
`default_nettype wire

// File: rtl/nios_switch_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nios_switch_debounce : one-bit synchronizer + debounce FSM -- rev 1.0
// ---------------------------------------------------------------------------
module nios_switch_debounce
  import nios_switch_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic raw_i,
  output logic      sync_o,
  output logic      db_o,
  output logic      rise_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // The cycle that enters COUNTING is the first stable sample, so the last
  // sample sees DEBOUNCE_CYCLES-2; db then lands DEBOUNCE_CYCLES+2 edges after the step.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

  logic          meta_q;
  logic          sync_q;
  logic          db_q;
  logic          db_d;
  db_state_e     state_q;
  db_state_e     state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      db_q    <= 1'b0;
      state_q <= STABLE;
      cnt_q   <= '0;
    end else begin
      meta_q  <= raw_i;
      sync_q  <= meta_q;
      db_q    <= db_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    case (state_q)
      STABLE: begin
        if (sync_q != db_q) begin
          state_d = COUNTING;
          cnt_d   = '0;
        end
      end
      COUNTING: begin
        if (sync_q == db_q) begin
          state_d = STABLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE;
          db_d    = sync_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = STABLE;
    endcase
  end

  assign sync_o = sync_q;
  assign db_o   = db_q;
  assign rise_o = db_d & ~db_q;

endmodule
`default_nettype wire

// File: rtl/nios_switch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nios_switch_ctrl : debounced switch PIO with edge capture and IRQ -- rev 1.0
// ---------------------------------------------------------------------------
module nios_switch_ctrl
  import nios_switch_ctrl_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  wire logic             clk,
  input  wire logic             reset,
  nios_switch_ctrl_if.slave     bus,
  input  wire logic [WIDTH-1:0] in_port,
  output logic                  irq
);

  logic [WIDTH-1:0] sync_w;
  logic [WIDTH-1:0] db_w;
  logic [WIDTH-1:0] rise_w;

  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] edge_d;
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;
  logic             irq_q;
  logic             wr_en;
  logic             unused_wdata;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      nios_switch_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .raw_i  (in_port[gi]),
        .sync_o (sync_w[gi]),
        .db_o   (db_w[gi]),
        .rise_o (rise_w[gi])
      );
    end
  endgenerate

  assign wr_en        = bus.chipselect && bus.write;
  assign unused_wdata = ^bus.writedata;

  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q;
    if (wr_en && (bus.address == ADDR_MASK)) begin
      mask_d = bus.writedata[WIDTH-1:0];
    end
    if (wr_en && (bus.address == ADDR_EDGE)) begin
      edge_d = edge_q & ~bus.writedata[WIDTH-1:0];
    end
    // A rise on the same cycle as a clear must survive.
    edge_d = edge_d | rise_w;
  end

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_DATA: readdata_d[WIDTH-1:0] = db_w;
      ADDR_RAW:  readdata_d[WIDTH-1:0] = sync_w;
      ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_q;
      default:   readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q     <= '0;
      edge_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      readdata_q <= readdata_d;
      irq_q      <= |(edge_q & mask_q);
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_nios_switch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_nios_switch_ctrl : scoreboard bench with behavioural reference model -- rev 1.0
// ---------------------------------------------------------------------------
module tb_nios_switch_ctrl;
  import nios_switch_ctrl_pkg::*;

  localparam int W = 4;
  localparam int D = 4;

  typedef struct packed {
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] in_port = '0;
  logic         irq;

  nios_switch_ctrl_if bus ();

  nios_switch_ctrl #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  // reference model state
  logic [W-1:0] m_s1, m_s2, m_db, m_mask, m_edge;
  int           m_run[W];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // A level becomes the debounced level once the synchronized input has
  // disagreed with it for D consecutive cycles.
  task automatic model_step();
    exp_t         e;
    logic [W-1:0] new_db;
    e = '0;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_mask = '0; m_edge = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      case (bus.address)
        2'd0: e.rd[W-1:0] = m_db;
        2'd1: e.rd[W-1:0] = m_s2;
        2'd2: e.rd[W-1:0] = m_mask;
        default: e.rd[W-1:0] = m_edge;
      endcase
      e.irq  = |(m_edge & m_mask);
      new_db = m_db;
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            new_db[i] = m_s2[i];
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      if (bus.chipselect && bus.write && bus.address == 2'd2) m_mask = bus.writedata[W-1:0];
      if (bus.chipselect && bus.write && bus.address == 2'd3) m_edge = m_edge & ~bus.writedata[W-1:0];
      m_edge = m_edge | (new_db & ~m_db);
      m_db   = new_db;
      m_s2   = m_s1;
      m_s1   = in_port;
    end
    exp_q.push_back(e);
  endtask

  initial begin : model_proc
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin : monitor_proc
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty: got no expected entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("sb_readdata", bus.readdata, e.rd);
        check("sb_irq", {31'd0, irq}, {31'd0, e.irq});
      end
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.chipselect = 1'b1; bus.write = 1'b1; bus.writedata = d;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write = 1'b0;
  endtask

  task automatic set_addr(input logic [1:0] a);
    @(negedge clk);
    bus.address = a;
  endtask

  initial begin : main
    logic [1:0] ra;
    bus.address = '0; bus.chipselect = 1'b0; bus.write = 1'b0; bus.writedata = '0;
    repeat (3) @(negedge clk);
    check("reset_readdata", bus.readdata, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    reset = 1'b0;

    // glitch on bit2 shorter than the debounce window
    set_addr(2'd1);
    in_port = 4'b0100;
    repeat (3) @(negedge clk);
    check("raw_during_pulse", bus.readdata, 32'h4);
    in_port = 4'b0000;
    repeat (10) @(negedge clk);
    bus.address = 2'd0;
    @(negedge clk);
    check("glitch_db", bus.readdata, 32'h0);
    bus.address = 2'd3;
    @(negedge clk);
    check("glitch_edge", bus.readdata, 32'h0);

    // clean step on bit0: db after D+2 edges, visible one edge later
    bus.address = 2'd0;
    in_port = 4'b0001;
    repeat (6) @(negedge clk);
    check("step_db_early", bus.readdata, 32'h0);
    @(negedge clk);
    check("step_db", bus.readdata, 32'h1);
    bus.address = 2'd3;
    @(negedge clk);
    check("step_edge", bus.readdata, 32'h1);

    // masked interrupt on bit1, then write-1-clear
    bus_write(2'd2, 32'h2);
    in_port = 4'b0011;
    repeat (6) @(negedge clk);
    check("irq_before", {31'd0, irq}, 32'h0);
    @(negedge clk);
    check("irq_asserted", {31'd0, irq}, 32'h1);
    bus_write(2'd3, 32'h2);
    check("irq_hold", {31'd0, irq}, 32'h1);
    @(negedge clk);
    check("irq_cleared", {31'd0, irq}, 32'h0);
    check("edge_after_clear", bus.readdata, 32'h1);

    // clear colliding with a new rise on bit0
    in_port = 4'b0010;
    repeat (10) @(negedge clk);
    bus_write(2'd3, 32'h1);
    in_port = 4'b0011;
    repeat (5) @(negedge clk);
    bus.address = 2'd3; bus.chipselect = 1'b1; bus.write = 1'b1; bus.writedata = 32'h1;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write = 1'b0;
    @(negedge clk);
    check("set_wins", bus.readdata, 32'h1);

    // reset while bit3 is mid-debounce
    in_port = 4'b0000;
    repeat (10) @(negedge clk);
    bus_write(2'd2, 32'hF);
    set_addr(2'd2);
    in_port = 4'b1000;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_reset_readdata", bus.readdata, 32'h0);
    check("async_reset_irq", {31'd0, irq}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bus.address = 2'd0;
    @(negedge clk);
    check("post_reset_db", bus.readdata, 32'h0);
    bus.address = 2'd3;
    repeat (10) @(negedge clk);
    check("post_reset_edge", bus.readdata, 32'h8);
    check("post_reset_irq", {31'd0, irq}, 32'h0);

    // writes to read-only register and out-of-range data bits
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus.address = 2'd0;
    @(negedge clk);
    check("ro_data", bus.readdata, 32'h8);
    bus.address = 2'd2;
    @(negedge clk);
    check("mask_width", bus.readdata, 32'hF);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) in_port = in_port ^ W'($urandom);
      ra = 2'($urandom);
      bus.address    = ra;
      bus.chipselect = ($urandom_range(0, 3) == 0);
      bus.write      = ($urandom_range(0, 1) == 0);
      bus.writedata  = $urandom;
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
      end
    end
    bus.chipselect = 1'b0; bus.write = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
